dmem_access_unit: RTL

//  Memory-stage access controller. Sits directly downstream of the pipelined datapath.

---
 rtl/dmem_access_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/dmem_access_unit.sv
// Memory-stage access controller: turns M-stage loads/stores into a ready-handshaked
// memory request, stalls the pipeline until completion, and flags misalignment/timeouts.
module dmem_access_unit #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic        err_clr,
  output logic        misalign_err,
  output logic        timeout_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        read_data_q, read_data_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [29:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               misalign_q, misalign_d;
  logic               timeout_q, timeout_d;

  logic access;
  logic aligned;
  logic misalign_set;
  logic timeout_set;

  assign access  = MemReadM | MemWriteM;
  assign aligned = (ALUOutM[1:0] == 2'b00);

  // Next-state, datapath capture and stall request
  always_comb begin
    state_d      = state_q;
    read_data_d  = read_data_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cnt_d        = cnt_q;
    misalign_set = 1'b0;
    timeout_set  = 1'b0;
    StallM       = 1'b0;

    case (state_q)
      S_IDLE: begin
        StallM = access;
        if (access) begin
          if (aligned) begin
            state_d     = S_REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = MemWriteM;
            mem_addr_d  = ALUOutM[31:2];
            mem_wdata_d = WriteDataM;
            cnt_d       = '0;
          end else begin
            state_d      = S_DONE;
            misalign_set = 1'b1;
            read_data_d  = '0;
          end
        end
      end
      S_REQ: begin
        StallM = 1'b1;
        if (mem_ready) begin
          state_d     = S_DONE;
          mem_req_d   = 1'b0;
          read_data_d = mem_we_q ? 32'h0 : mem_rdata;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d     = S_DONE;
          mem_req_d   = 1'b0;
          timeout_set = 1'b1;
          read_data_d = mem_we_q ? 32'h0 : ERR_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    // Sticky flags: a coincident set beats the clear
    misalign_d = (misalign_q & ~err_clr) | misalign_set;
    timeout_d  = (timeout_q & ~err_clr) | timeout_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      read_data_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cnt_q       <= '0;
      misalign_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      read_data_q <= read_data_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cnt_q       <= cnt_d;
      misalign_q  <= misalign_d;
      timeout_q   <= timeout_d;
    end
  end

  assign ReadDataM    = read_data_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign misalign_err = misalign_q;
  assign timeout_err  = timeout_q;

endmodule
